// File: rtl/ttl_pkg.sv
// Shared types and constants for the clocked TTL chip models.
// Mode encodings follow the chip's S1/S0 select pins directly.
package ttl_pkg;

    localparam int LS299_W = 8;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } ls299_mode_t;

    function automatic ls299_mode_t ls299_decode_mode(input logic s1, input logic s0);
        return ls299_mode_t'({s1, s0});
    endfunction

endpackage

// File: rtl/ttl_edge_det.sv
// Registered edge detector for chip clock pins sampled on the system clock.
// The flag is registered, so it is high for exactly one clk per detected edge.
module ttl_edge_det #(
    parameter bit CP_EDGE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic edge_out
);

    logic sig_prev;

    // sig_prev resets low, so a pin already high at reset release reads as a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_prev <= 1'b0;
            edge_out <= 1'b0;
        end else begin
            sig_prev <= sig_in;
            if (CP_EDGE)
                edge_out <= sig_in & ~sig_prev;
            else
                edge_out <= ~sig_in & sig_prev;
        end
    end

endmodule

// File: rtl/ls299.sv
// 74LS299 8-bit universal shift/storage register with bidirectional bus I/O.
// The chip CP pin is edge-detected on clk; the parent resolves the tri-state bus.
module ls299
    import ttl_pkg::*;
#(
    parameter int WIDTH   = LS299_W,
    parameter bit CP_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cp,
    input  logic             mr_n,
    input  logic             s0,
    input  logic             s1,
    input  logic             oe1_n,
    input  logic             oe2_n,
    input  logic             ds0,
    input  logic             ds7,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic             io_oe,
    output logic             q0,
    output logic             q7
);

    logic             cp_edge;
    ls299_mode_t      mode;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    ttl_edge_det #(
        .CP_EDGE (CP_EDGE)
    ) u_cp_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .sig_in   (cp),
        .edge_out (cp_edge)
    );

    assign mode = ls299_decode_mode(s1, s0);

    // Master reset beats any edge; "right" moves data from Q0 toward Q7.
    always_comb begin
        data_next = data_reg;
        if (!mr_n) begin
            data_next = '0;
        end else if (cp_edge) begin
            case (mode)
                HOLD:    data_next = data_reg;
                SHR:     data_next = {data_reg[WIDTH-2:0], ds0};
                SHL:     data_next = {ds7, data_reg[WIDTH-1:1]};
                LOAD:    data_next = io_in;
                default: data_next = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            data_reg <= '0;
        else
            data_reg <= data_next;
    end

    assign io_out = data_reg;
    assign q0     = data_reg[0];
    assign q7     = data_reg[WIDTH-1];

    // Drive is dropped in load mode so the chip never fights the bus it samples.
    assign io_oe  = ~oe1_n & ~oe2_n & ~(s1 & s0);

endmodule

// File: tb/tb_ls299.sv
// Self-checking bench for ls299: a rising-edge and a falling-edge instance share stimulus.
// Table vectors, hand sequences for corner cases, then randomized pulses against a model.
module tb_ls299;
    import ttl_pkg::*;

    localparam int W = LS299_W;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cp;
    logic         mr_n;
    logic         s0;
    logic         s1;
    logic         oe1_n;
    logic         oe2_n;
    logic         ds0;
    logic         ds7;
    logic [W-1:0] io_in;

    logic [W-1:0] io_out_r;
    logic         io_oe_r;
    logic         q0_r;
    logic         q7_r;
    logic [W-1:0] io_out_f;
    logic         io_oe_f;
    logic         q0_f;
    logic         q7_f;

    int assert_count = 0;
    int fail_count   = 0;

    logic [W-1:0] model_r;
    logic [W-1:0] model_f;

    typedef struct {
        logic [1:0]   mode;
        logic         ds0;
        logic         ds7;
        logic [W-1:0] io_in;
        logic [W-1:0] exp_reg;
    } vec_t;

    vec_t vecs [17];

    ls299 #(.WIDTH(W), .CP_EDGE(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cp      (cp),
        .mr_n    (mr_n),
        .s0      (s0),
        .s1      (s1),
        .oe1_n   (oe1_n),
        .oe2_n   (oe2_n),
        .ds0     (ds0),
        .ds7     (ds7),
        .io_in   (io_in),
        .io_out  (io_out_r),
        .io_oe   (io_oe_r),
        .q0      (q0_r),
        .q7      (q7_r)
    );

    ls299 #(.WIDTH(W), .CP_EDGE(1'b0)) dut_fall (
        .clk     (clk),
        .reset_n (reset_n),
        .cp      (cp),
        .mr_n    (mr_n),
        .s0      (s0),
        .s1      (s1),
        .oe1_n   (oe1_n),
        .oe2_n   (oe2_n),
        .ds0     (ds0),
        .ds7     (ds7),
        .io_in   (io_in),
        .io_out  (io_out_f),
        .io_oe   (io_oe_f),
        .q0      (q0_f),
        .q7      (q7_f)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural register model: shifts expressed as multiply/divide by two.
    function automatic logic [W-1:0] ref_next(input logic [1:0] mode, input logic [W-1:0] cur,
                                              input logic d0, input logic d7,
                                              input logic [W-1:0] din);
        int v;
        v = int'(cur);
        case (mode)
            2'd0:    return cur;
            2'd1:    return W'((v * 2 + (d0 ? 1 : 0)) % (1 << W));
            2'd2:    return W'(v / 2 + (d7 ? (1 << (W - 1)) : 0));
            default: return din;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpPulse();
        cp = 1'b1;
        tick(3);
        cp = 1'b0;
        tick(3);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] exp_r,
                               input logic [W-1:0] exp_f, input logic exp_oe);
        check({tag, " io_out"},      32'(io_out_r), 32'(exp_r));
        check({tag, " q0"},          32'(q0_r),     32'(exp_r[0]));
        check({tag, " q7"},          32'(q7_r),     32'(exp_r[W-1]));
        check({tag, " io_oe"},       32'(io_oe_r),  32'(exp_oe));
        check({tag, " fall io_out"}, 32'(io_out_f), 32'(exp_f));
        check({tag, " fall q0"},     32'(q0_f),     32'(exp_f[0]));
        check({tag, " fall q7"},     32'(q7_f),     32'(exp_f[W-1]));
        check({tag, " fall io_oe"},  32'(io_oe_f),  32'(exp_oe));
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic d0, input logic d7,
                                 input logic [W-1:0] din);
        {s1, s0} = mode;
        ds0      = d0;
        ds7      = d7;
        io_in    = din;
        cpPulse();
        model_r = ref_next(mode, model_r, d0, d7, din);
        model_f = ref_next(mode, model_f, d0, d7, din);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 1'b1, 1'b0, 8'h00, 8'h4B};
        vecs[1]  = '{2'b01, 1'b1, 1'b0, 8'h00, 8'h97};
        vecs[2]  = '{2'b01, 1'b1, 1'b0, 8'h00, 8'h2F};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 8'h81, 8'h81};
        vecs[4]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h40};
        vecs[5]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h20};
        vecs[6]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h10};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h08};
        vecs[8]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h04};
        vecs[9]  = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h02};
        vecs[10] = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h01};
        vecs[11] = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[12] = '{2'b00, 1'b1, 1'b1, 8'hFF, 8'h00};
        vecs[13] = '{2'b11, 1'b0, 1'b0, 8'h5A, 8'h5A};
        vecs[14] = '{2'b10, 1'b0, 1'b1, 8'h00, 8'hAD};
        vecs[15] = '{2'b00, 1'b0, 1'b0, 8'h00, 8'hAD};
        vecs[16] = '{2'b01, 1'b0, 1'b0, 8'h00, 8'h5A};

        reset_n = 1'b0;
        cp      = 1'b0;
        mr_n    = 1'b1;
        {s1, s0} = 2'b11;
        oe1_n   = 1'b0;
        oe2_n   = 1'b0;
        ds0     = 1'b0;
        ds7     = 1'b0;
        io_in   = 8'hFF;
        model_r = '0;
        model_f = '0;

        // Reset held while cp toggles, then released with cp low.
        repeat (4) begin
            cp = ~cp;
            tick(1);
        end
        checkOutput("reset", 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;
        tick(4);
        checkOutput("reset_release", 8'h00, 8'h00, 1'b0);

        // Parallel load: visible two clks after cp rises.
        io_in = 8'hA5;
        cp    = 1'b1;
        tick(1);
        check("load_latency1 io_out", 32'(io_out_r), 32'h00);
        check("load_latency1 io_oe",  32'(io_oe_r),  32'h0);
        tick(1);
        check("load_latency2 io_out", 32'(io_out_r), 32'hA5);
        check("load_latency2 io_oe",  32'(io_oe_r),  32'h0);
        check("load_rise fall io_out", 32'(io_out_f), 32'h00);
        cp = 1'b0;
        tick(3);
        model_r = 8'hA5;
        model_f = 8'hA5;
        checkOutput("load_fall", 8'hA5, 8'hA5, 1'b0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].ds0, vecs[i].ds7, vecs[i].io_in);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_reg, vecs[i].exp_reg,
                        !(vecs[i].mode == 2'b11));
        end

        // Output-enable matrix with the register holding 5A.
        {s1, s0} = 2'b00;
        for (int i = 0; i < 4; i++) begin
            {oe1_n, oe2_n} = 2'(i);
            #1;
            checkOutput($sformatf("oe_matrix%0d", i), model_r, model_f, i == 0);
        end
        {oe1_n, oe2_n} = 2'b00;
        {s1, s0} = 2'b11;
        #1;
        checkOutput("oe_load_mode", model_r, model_f, 1'b0);

        // Edge polarity: rising instance moves on the rise, falling instance on the fall.
        {s1, s0} = 2'b01;
        ds0 = 1'b1;
        cp  = 1'b1;
        tick(3);
        model_r = ref_next(2'b01, model_r, 1'b1, 1'b0, io_in);
        checkOutput("edge_pol_rise", model_r, model_f, 1'b1);
        cp = 1'b0;
        tick(3);
        model_f = ref_next(2'b01, model_f, 1'b1, 1'b0, io_in);
        checkOutput("edge_pol_fall", model_r, model_f, 1'b1);

        // Clear coincident with a load edge, then cp held high.
        {s1, s0} = 2'b11;
        io_in = 8'h3C;
        cp    = 1'b1;
        mr_n  = 1'b0;
        tick(3);
        model_r = '0;
        model_f = '0;
        checkOutput("clear_prio", 8'h00, 8'h00, 1'b0);
        mr_n = 1'b1;
        tick(10);
        checkOutput("clear_hold_cp", 8'h00, 8'h00, 1'b0);
        {s1, s0} = 2'b00;
        cp = 1'b0;
        tick(3);
        checkOutput("clear_cp_low", 8'h00, 8'h00, 1'b1);

        // cp toggling under master reset has no effect.
        applyStimulus(2'b11, 1'b0, 1'b0, 8'h77);
        {s1, s0} = 2'b01;
        ds0  = 1'b1;
        mr_n = 1'b0;
        repeat (4) begin
            cp = ~cp;
            tick(2);
        end
        mr_n = 1'b1;
        tick(3);
        model_r = '0;
        model_f = '0;
        checkOutput("mr_cp_toggle", 8'h00, 8'h00, 1'b1);

        // Async reset mid-shift, released with cp high (counts as a rising edge).
        applyStimulus(2'b11, 1'b0, 1'b0, 8'hC3);
        {s1, s0} = 2'b01;
        ds0 = 1'b1;
        cp  = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        model_r = '0;
        model_f = '0;
        checkOutput("reset_mid_shift", 8'h00, 8'h00, 1'b1);
        reset_n = 1'b1;
        tick(3);
        model_r = 8'h01;
        checkOutput("release_cp_high", model_r, model_f, 1'b1);
        {s1, s0} = 2'b00;
        cp = 1'b0;
        tick(3);
        checkOutput("release_hold", model_r, model_f, 1'b1);

        // Randomized pulses with occasional master reset.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rmode;
            logic         rd0;
            logic         rd7;
            logic [W-1:0] rdin;
            logic         rclr;
            rmode = 2'($urandom_range(0, 3));
            rd0   = 1'($urandom_range(0, 1));
            rd7   = 1'($urandom_range(0, 1));
            rdin  = W'($urandom);
            rclr  = ($urandom_range(0, 7) == 0);
            oe1_n = 1'($urandom_range(0, 1));
            oe2_n = 1'($urandom_range(0, 1));
            if (rclr) begin
                {s1, s0} = rmode;
                ds0   = rd0;
                ds7   = rd7;
                io_in = rdin;
                mr_n  = 1'b0;
                cpPulse();
                mr_n  = 1'b1;
                model_r = '0;
                model_f = '0;
            end else begin
                applyStimulus(rmode, rd0, rd7, rdin);
            end
            checkOutput($sformatf("rand%0d", i), model_r, model_f,
                        !oe1_n && !oe2_n && (rmode != 2'b11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
